// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the op-class helper.
package mdu_pkg;

  localparam int MDU_OP_W         = 3;
  localparam int MDU_MULT_LAT_DEF = 5;
  localparam int MDU_DIV_LAT_DEF  = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MFHI  = 3'd4,
    MDU_MFLO  = 3'd5,
    MDU_MTHI  = 3'd6,
    MDU_MTLO  = 3'd7
  } mdu_op_e;

  // Multi-cycle ops (MULT/MULTU/DIV/DIVU) all sit in the lower half of the encoding.
  function automatic logic mdu_is_long(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi, lo} result for MULT/MULTU/DIV/DIVU.
// wr_o is low when the result must not reach HI/LO (divide by zero, non-arith op).
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wr_o
);

  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Signed divide works on magnitudes so the quotient truncates toward zero
  // and the remainder inherits the dividend's sign; -2^31 / -1 wraps to -2^31.
  always_comb begin
    a_mag = rs_i[31] ? (~rs_i + 32'd1) : rs_i;
    b_mag = rt_i[31] ? (~rt_i + 32'd1) : rt_i;
    if (op_i == MDU_MULT) begin
      mul_a = {{32{rs_i[31]}}, rs_i};
      mul_b = {{32{rt_i[31]}}, rt_i};
    end else begin
      mul_a = {32'd0, rs_i};
      mul_b = {32'd0, rt_i};
    end
  end

  assign prod = mul_a * mul_b;

  always_comb begin
    q_mag = '0;
    r_mag = '0;
    hi_o  = '0;
    lo_o  = '0;
    wr_o  = 1'b0;
    case (op_i)
      MDU_MULT, MDU_MULTU: begin
        hi_o = prod[63:32];
        lo_o = prod[31:0];
        wr_o = 1'b1;
      end
      MDU_DIV: begin
        if (rt_i != '0) begin
          q_mag = a_mag / b_mag;
          r_mag = a_mag % b_mag;
          lo_o  = (rs_i[31] ^ rt_i[31]) ? (~q_mag + 32'd1) : q_mag;
          hi_o  = rs_i[31] ? (~r_mag + 32'd1) : r_mag;
          wr_o  = 1'b1;
        end
      end
      MDU_DIVU: begin
        if (rt_i != '0) begin
          lo_o = rs_i / rt_i;
          hi_o = rs_i % rt_i;
          wr_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_controller.sv
// E-stage multiply/divide sequencer: fixed-latency busy counter, pending
// result, architectural HI/LO and the D-stage stall request.
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT_DEF,
  parameter int DIV_LAT  = MDU_DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                e_mdu_valid,
  input  logic [MDU_OP_W-1:0] e_mdu_op,
  input  logic [31:0]         e_rs,
  input  logic [31:0]         e_rt,
  input  logic                d_is_mdu,
  output logic                start,
  output logic                busy,
  output logic                stall_req,
  output logic [31:0]         hi,
  output logic [31:0]         lo,
  output logic [31:0]         mdu_out
);

  // Handshake: an op is consumed only in a cycle where e_mdu_valid=1 and busy=0;
  // ops presented while busy are dropped, upstream holds them via stall_req.

  mdu_op_e     op;
  logic        accept;
  logic        done;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;

  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [31:0]      hi_q,      hi_d;
  logic [31:0]      lo_q,      lo_d;

  assign op     = mdu_op_e'(e_mdu_op);
  assign busy   = (cnt_q != '0);
  assign accept = e_mdu_valid & ~busy;
  assign start  = accept & mdu_is_long(op);
  assign done   = (cnt_q == CNT_W'(1));

  assign stall_req = d_is_mdu & (start | busy);
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    mdu_out = '0;
    if (op == MDU_MFHI)      mdu_out = hi_q;
    else if (op == MDU_MFLO) mdu_out = lo_q;
  end

  mdu_arith u_arith (
    .op_i (op),
    .rs_i (e_rs),
    .rt_i (e_rt),
    .hi_o (res_hi),
    .lo_o (res_lo),
    .wr_o (res_wr)
  );

  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (start) begin
      cnt_d     = mdu_is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      pend_hi_d = res_hi;
      pend_lo_d = res_lo;
      pend_wr_d = res_wr;
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Completion and MT* are mutually exclusive: MT* needs busy=0.
    if (done && pend_wr_q) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end
    if (accept && op == MDU_MTHI) hi_d = e_rs;
    if (accept && op == MDU_MTLO) lo_d = e_rs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_controller.sv
// Directed bench for mdu_controller: latency, arithmetic, MT/MF, stall,
// ignored-while-busy and mid-operation reset.
module tb_mdu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_mdu_valid;
  logic [2:0]  e_mdu_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_is_mdu;
  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_hi;
  logic [31:0] model_lo;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  always #5 clk = ~clk;

  mdu_controller dut (
    .clk         (clk),
    .reset       (reset),
    .e_mdu_valid (e_mdu_valid),
    .e_mdu_op    (e_mdu_op),
    .e_rs        (e_rs),
    .e_rt        (e_rt),
    .d_is_mdu    (d_is_mdu),
    .start       (start),
    .busy        (busy),
    .stall_req   (stall_req),
    .hi          (hi),
    .lo          (lo),
    .mdu_out     (mdu_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one long op, walk the busy window, then check the committed result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic dm);
    e_mdu_valid = 1'b1;
    e_mdu_op    = op;
    e_rs        = a;
    e_rt        = b;
    d_is_mdu    = dm;
    #1;
    check("issue_start", {31'd0, start}, 32'd1);
    check("issue_busy", {31'd0, busy}, 32'd0);
    check("issue_stall", {31'd0, stall_req}, {31'd0, dm});
    tick;
    e_mdu_valid = 1'b0;
    #1;
    for (int i = 1; i <= lat; i++) begin
      check("busy_win", {31'd0, busy}, 32'd1);
      check("busy_stall", {31'd0, stall_req}, {31'd0, dm});
      check("busy_hi_hold", hi, model_hi);
      check("busy_lo_hold", lo, model_lo);
      tick;
    end
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_stall", {31'd0, stall_req}, 32'd0);
    check("done_hi", hi, exp_hi);
    check("done_lo", lo, exp_lo);
    model_hi = exp_hi;
    model_lo = exp_lo;
    d_is_mdu = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    e_mdu_valid = 1'b0;
    e_mdu_op    = OP_MTHI;
    e_rs        = '0;
    e_rt        = '0;
    d_is_mdu    = 1'b0;
    model_hi    = '0;
    model_lo    = '0;
    tick;
    tick;
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_mdu_out", mdu_out, 32'd0);

    // Back-to-back issues: each run_op starts in the cycle after the previous completion.
    run_op(OP_MULT,  32'd3,        32'hFFFF_FFFE, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    run_op(OP_DIVU,  32'd7,        32'd2,         10, 32'd1,         32'd3,         1'b0);
    run_op(OP_DIVU,  32'd5,        32'd0,         10, 32'd1,         32'd3,         1'b1);
    run_op(OP_DIV,   32'd7,        32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD, 1'b0);

    // MTHI / MFHI, MTLO / MFLO
    e_mdu_valid = 1'b1;
    e_mdu_op    = OP_MTHI;
    e_rs        = 32'h1234_5678;
    #1;
    check("mthi_start", {31'd0, start}, 32'd0);
    tick;
    e_mdu_op = OP_MFHI;
    #1;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'hFFFF_FFFD);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mfhi_out", mdu_out, 32'h1234_5678);
    e_mdu_op = OP_MTLO;
    e_rs     = 32'hCAFE_F00D;
    tick;
    e_mdu_op = OP_MFLO;
    #1;
    check("mtlo_lo", lo, 32'hCAFE_F00D);
    check("mflo_out", mdu_out, 32'hCAFE_F00D);
    check("mtlo_hi_keep", hi, 32'h1234_5678);
    model_hi = 32'h1234_5678;
    model_lo = 32'hCAFE_F00D;
    tick;
    e_mdu_valid = 1'b0;

    // Ops presented while busy must be ignored.
    e_mdu_valid = 1'b1;
    e_mdu_op    = OP_MULT;
    e_rs        = 32'd2;
    e_rt        = 32'd3;
    #1;
    check("ign_issue_start", {31'd0, start}, 32'd1);
    tick;
    e_rs = 32'd100;
    e_rt = 32'd100;
    #1;
    check("ign_mult_start", {31'd0, start}, 32'd0);
    check("ign_mult_busy", {31'd0, busy}, 32'd1);
    tick;
    e_mdu_op = OP_MTLO;
    e_rs     = 32'hDEAD_BEEF;
    tick;
    e_mdu_op = OP_DIV;
    e_rt     = 32'd1;
    #1;
    check("ign_div_start", {31'd0, start}, 32'd0);
    tick;
    e_mdu_valid = 1'b0;
    tick;
    check("ign_busy_last", {31'd0, busy}, 32'd1);
    check("ign_lo_hold", lo, 32'hCAFE_F00D);
    tick;
    check("ign_done_busy", {31'd0, busy}, 32'd0);
    check("ign_done_hi", hi, 32'd0);
    check("ign_done_lo", lo, 32'd6);

    // Reset during the third busy cycle of a DIV discards the pending result.
    e_mdu_valid = 1'b1;
    e_mdu_op    = OP_DIV;
    e_rs        = 32'd100;
    e_rt        = 32'd7;
    d_is_mdu    = 1'b1;
    #1;
    check("rdiv_start", {31'd0, start}, 32'd1);
    tick;
    e_mdu_valid = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    check("rdiv_busy", {31'd0, busy}, 32'd0);
    check("rdiv_stall", {31'd0, stall_req}, 32'd0);
    check("rdiv_hi", hi, 32'd0);
    check("rdiv_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick;
    check("rdiv_late_hi", hi, 32'd0);
    check("rdiv_late_lo", lo, 32'd0);
    check("rdiv_late_busy", {31'd0, busy}, 32'd0);
    d_is_mdu = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
